ula_mc: RTL and testbench

ULA_MC -- requirements
Module: ula_mc

---
 rtl/ula_mc.sv | 212 +++++++++++++++++++++
 tb/tb_ula_mc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_mc.sv
`default_nettype none
// ============================================================================
//  Module      : ula_mc
//  Description : Multi-cycle integer ALU with a valid/ready handshake on both
//                sides. Non-shift operations and zero-amount shifts complete
//                in one cycle. A shift by k moves one bit per cycle, so its
//                result is ready 1+k cycles after the operation is accepted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock; all state changes on the rising edge
//    reset      in   synchronous, active-high reset
//    in_valid   in   op/s1/s2 are valid
//    in_ready   out  block can accept an operation (IDLE only)
//    op         in   0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA
//    s1, s2     in   operands; s2[SHAMT_W-1:0] is the shift amount
//    out_valid  out  res/flags are valid (DONE only)
//    out_ready  in   consumer takes the result
//    res        out  registered result
//    flags      out  registered {Z,N,C,V,LT,LTU}
// ============================================================================
module ula_mc #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   s1,
  input  logic [WIDTH-1:0]   s2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic [5:0]         flags
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     sh_q, sh_d;      // latched s1, then the shift in progress
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [5:0]           flags_q, flags_d;

  // --------------------------------------------------------------------------
  // Single-cycle evaluation of the operation presented on the inputs.
  // One adder serves ADD and the subtract-based ops (SUB/SLT/SLTU).
  // --------------------------------------------------------------------------
  logic                 is_sub;
  logic [WIDTH-1:0]     b_opnd;
  logic [WIDTH:0]       sum;
  logic                 c_add, v_add, lt_s, ltu_s;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v, alu_lt, alu_ltu;
  logic [5:0]           alu_flags;

  always_comb begin
    is_sub  = (op != OP_ADD);
    b_opnd  = is_sub ? ~s2 : s2;
    sum     = {1'b0, s1} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
    c_add   = sum[WIDTH];
    // Overflow: both adder inputs share a sign the sum does not.
    v_add   = (s1[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != s1[WIDTH-1]);
    lt_s    = sum[WIDTH-1] ^ v_add;
    ltu_s   = ~c_add;
    shamt   = s2[SHAMT_W-1:0];

    is_shift = 1'b0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_lt   = 1'b0;
    alu_ltu  = 1'b0;

    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = c_add;
        alu_v   = v_add;
      end
      OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = c_add;
        alu_v   = v_add;
        alu_lt  = lt_s;
        alu_ltu = ltu_s;
      end
      OP_AND:  alu_res = s1 & s2;
      OP_OR:   alu_res = s1 | s2;
      OP_XOR:  alu_res = s1 ^ s2;
      OP_SLT: begin
        alu_res = {{(WIDTH-1){1'b0}}, lt_s};
        alu_lt  = lt_s;
        alu_ltu = ltu_s;
      end
      OP_SLTU: begin
        alu_res = {{(WIDTH-1){1'b0}}, ltu_s};
        alu_lt  = lt_s;
        alu_ltu = ltu_s;
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        // Zero-amount shift finishes immediately with s1 unchanged.
        is_shift = 1'b1;
        alu_res  = s1;
      end
      default: alu_res = '0;   // illegal op: res=0, Z=1 only
    endcase

    alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v, alu_lt, alu_ltu};
  end

  // One-bit step of the latched shift; SRA replicates the latched sign bit.
  logic [WIDTH-1:0] sh_step;

  always_comb begin
    case (op_q)
      OP_SLL:  sh_step = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRA:  sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_step = {1'b0, sh_q[WIDTH-1:1]};
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op;
          sh_d = s1;
          if (is_shift && (shamt != '0)) begin
            state_d = ST_SHIFT;
            cnt_d   = shamt;
          end else begin
            state_d = ST_DONE;
            res_d   = alu_res;
            flags_d = alu_flags;
          end
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - SHAMT_W'(1);
        // The last step's value goes straight into the result register.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
          res_d   = sh_step;
          flags_d = {(sh_step == '0), sh_step[WIDTH-1], 4'b0000};
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula_mc
//  Description : Self-checking bench for ula_mc: directed vector table,
//                randomized operations against an arithmetic reference model,
//                reset-abort sequences, and an 8-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [63:0] s1, s2, res;
  logic [5:0]  flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  op8;
  logic [7:0]  s1_8, s2_8, res8;
  logic [5:0]  flags8;

  always #5 clk = ~clk;

  ula_mc #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .s1(s1), .s2(s2), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flags(flags)
  );

  ula_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .s1(s1_8), .s2(s2_8), .out_valid(out_valid8), .out_ready(out_ready8),
    .res(res8), .flags(flags8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic void model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic [5:0] f, output int lat);
    logic [64:0]        us;
    logic signed [64:0] ss;
    logic signed [63:0] as;
    logic               c, v, lt, ltu;
    int                 k;
    k   = int'(b[5:0]);
    lat = 1;
    c = 1'b0; v = 1'b0; lt = 1'b0; ltu = 1'b0;
    as = a;
    r  = '0;
    case (o)
      4'd0: begin
        us = {1'b0, a} + {1'b0, b};
        r  = us[63:0];
        c  = us[64];
        ss = $signed({a[63], a}) + $signed({b[63], b});
        v  = (ss[64] != ss[63]);
      end
      4'd1: begin
        r   = a - b;
        c   = (a >= b);
        ss  = $signed({a[63], a}) - $signed({b[63], b});
        v   = (ss[64] != ss[63]);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin lt = ($signed(a) < $signed(b)); ltu = (a < b); r = {63'd0, lt};  end
      4'd6: begin lt = ($signed(a) < $signed(b)); ltu = (a < b); r = {63'd0, ltu}; end
      4'd7: begin r = a << k;  lat = 1 + k; end
      4'd8: begin r = a >> k;  lat = 1 + k; end
      4'd9: begin r = as >>> k; lat = 1 + k; end
      default: r = '0;
    endcase
    f = {(r == 64'd0), r[63], c, v, lt, ltu};
  endfunction

  // Issue one operation, measure latency, check result, hold, then consume.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_r,
                        input logic [5:0] exp_f, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; s1 = a; s2 = b;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      // Traffic while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    check({nm, ".res"}, res, exp_r);
    check({nm, ".flags"}, 64'(flags), 64'(exp_f));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, ".hold_res"}, res, exp_r);
      check({nm, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({nm, ".hold_out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, ".consumed_out_valid"}, 64'(out_valid), 64'd0);
    check({nm, ".consumed_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run8(input string nm, input logic [3:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_r,
                      input logic [5:0] exp_f, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid8 = 1'b1; op8 = o; s1_8 = a; s2_8 = b;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    check({nm, ".res"}, 64'(res8), 64'(exp_r));
    check({nm, ".flags"}, 64'(flags8), 64'(exp_f));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({nm, ".in_ready"}, 64'(in_ready8), 64'd1);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] res;
    logic [5:0]  flags;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [63:0] ra, rb, er;
    logic [5:0]  ef;
    int          el;
    logic        seen;

    //          name          op     s1                       s2                       res                      {Z,N,C,V,LT,LTU} lat hold
    tbl[0] = '{"sub_neg",     4'd1, 64'd1,                   -64'sd45,                64'd46,                  6'b000001, 1,  0};
    tbl[1] = '{"sub_ovf",     4'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFF8, 64'd8,                   6'b001110, 1,  1};
    tbl[2] = '{"sub_min_max", 4'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                   6'b001110, 1,  0};
    tbl[3] = '{"sltu",        4'd6, 64'd12873481,            64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   6'b000001, 1,  0};
    tbl[4] = '{"slt",         4'd5, 64'd12873481,            64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   6'b100001, 1,  0};
    tbl[5] = '{"sra4",        4'd9, 64'h8000_0000_0000_0000, 64'd4,                   64'hF800_0000_0000_0000, 6'b010000, 5,  3};
    tbl[6] = '{"illegal",     4'd12,64'd5,                   64'd7,                   64'd0,                   6'b100000, 1,  0};
    tbl[7] = '{"sll0",        4'd7, 64'h8000_0000_0000_0001, 64'h40,                  64'h8000_0000_0000_0001, 6'b010000, 1,  0};
    tbl[8] = '{"add_wrap",    4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'd0,                   6'b101000, 1,  0};
    tbl[9] = '{"srl63",       4'd8, 64'h8000_0000_0000_0000, 64'd63,                  64'd1,                   6'b000000, 64, 0};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; s1 = '0; s2 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; s1_8 = '0; s2_8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.res", res, 64'd0);
    check("reset.flags", 64'(flags), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].nm, tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].res,
             tbl[i].flags, tbl[i].lat, tbl[i].hold);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 11));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 3) == 0) ra[63] = ~ra[63];
      model(ro, ra, rb, er, ef, el);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, er, ef, el,
             int'($urandom_range(0, 2)));
    end

    // Reset 10 cycles into a 63-step shift: aborted, nothing emitted
    @(negedge clk);
    in_valid = 1'b1; op = 4'd7; s1 = 64'h1234_5678_9ABC_DEF1; s2 = 64'd63;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.res", res, 64'd0);
    check("abort.flags", 64'(flags), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort.no_emit", 64'(seen), 64'd0);

    // Reset in DONE, with a competing accept on the reset edge
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; s1 = 64'd3; s2 = 64'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_done.out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("rst_done.in_ready", 64'(in_ready), 64'd1);
    check("rst_done.res", res, 64'd0);
    @(posedge clk); #1;
    check("rst_done.no_accept", 64'(out_valid), 64'd0);

    // 8-bit instance
    run8("w8_add", 4'd0, 8'h7F, 8'h01, 8'h80, 6'b010100, 1);
    run8("w8_sra3", 4'd9, 8'h80, 8'h03, 8'hF0, 6'b010000, 4);
    run8("w8_sub", 4'd1, 8'h05, 8'h05, 8'h00, 6'b101000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
